// File: rtl/mult_accumulator_pkg.sv
// Shared constants and state encoding for the multiply-accumulate stage
// and the 4-bit multiplier it consumes.
package mult_accumulator_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_accumulator_if.sv
// Operand handshake and result bus between a producer and mult_accumulator.
interface mult_accumulator_if
  import mult_accumulator_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int LEN_W = 8
);

  logic              i_start;
  logic [LEN_W-1:0]  i_len;
  logic              i_valid;
  logic [OP_W-1:0]   i_op1;
  logic [OP_W-1:0]   i_op2;
  logic              o_ready;
  logic              o_busy;
  logic [ACC_W-1:0]  o_acc;
  logic              o_ovf;
  logic              o_done;

  modport slave (
    input  i_start, i_len, i_valid, i_op1, i_op2,
    output o_ready, o_busy, o_acc, o_ovf, o_done
  );

  modport master (
    output i_start, i_len, i_valid, i_op1, i_op2,
    input  o_ready, o_busy, o_acc, o_ovf, o_done
  );

endinterface

// File: rtl/multiplier_4bit.sv
// Unsigned 4x4 combinational multiplier producing a full 8-bit product.
module multiplier_4bit
  import mult_accumulator_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_p
);

  assign o_p = PROD_W'(i_a) * PROD_W'(i_b);

endmodule

// File: rtl/mult_accumulator.sv
// Sequential multiply-accumulate: registers each handshaked product for one
// stage, then folds it into a saturating accumulator over i_len terms.
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int LEN_W = 8
)(
  input  logic               i_clk,
  input  logic               i_rst,
  mult_accumulator_if.slave  bus
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("mult_accumulator: ACC_W must be at least 8");
  end

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [LEN_W-1:0]   sum_cnt_q, sum_cnt_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               pvalid_q, pvalid_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [PROD_W-1:0]  prod_w;
  logic               ready;
  logic               xfer;
  logic [ACC_W:0]     sum;

  multiplier_4bit u_mul (
    .i_a (bus.i_op1),
    .i_b (bus.i_op2),
    .o_p (prod_w)
  );

  // Ready comes only from registered state so the producer never sees a
  // combinational path from its own i_valid.
  assign ready = (state_q == ACCUM) && (acc_cnt_q < len_q);
  assign xfer  = ready & bus.i_valid;
  assign sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    acc_cnt_d = acc_cnt_q;
    sum_cnt_d = sum_cnt_q;
    prod_d    = prod_q;
    pvalid_d  = xfer;
    acc_d     = acc_q;
    ovf_d     = ovf_q;

    if (xfer) begin
      prod_d    = prod_w;
      acc_cnt_d = acc_cnt_q + 1'b1;
    end

    // Once saturated, any further carry keeps the accumulator pinned at max.
    if (pvalid_q) begin
      sum_cnt_d = sum_cnt_q + 1'b1;
      if (sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          len_d     = bus.i_len;
          acc_d     = '0;
          ovf_d     = 1'b0;
          acc_cnt_d = '0;
          sum_cnt_d = '0;
          state_d   = (bus.i_len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer && (acc_cnt_d == len_q)) state_d = FLUSH;
      end
      FLUSH: begin
        if (pvalid_q && (sum_cnt_d == len_q)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      acc_cnt_q <= '0;
      sum_cnt_q <= '0;
      prod_q    <= '0;
      pvalid_q  <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      acc_cnt_q <= acc_cnt_d;
      sum_cnt_q <= sum_cnt_d;
      prod_q    <= prod_d;
      pvalid_q  <= pvalid_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_done  = (state_q == DONE);
  assign bus.o_acc   = acc_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Randomized self-checking bench for mult_accumulator against a sum-of-products
// reference clipped at the accumulator maximum.
module tb_mult_accumulator;

  localparam int ACC_W = 16;
  localparam int LEN_W = 9;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic i_clk;
  logic i_rst;

  int checks;
  int failures;

  logic [3:0] a_tab [512];
  logic [3:0] b_tab [512];

  mult_accumulator_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  mult_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one sequence from a_tab/b_tab. The expected result is the plain
  // sum of the products that actually handshook, clipped to the maximum.
  task automatic run_seq(input string tag, input int len, input int gap_max,
                         input bit stray, input bit chk_prod);
    longint total = 0;
    longint exp_acc;
    longint exp_prod = 0;
    int     sent = 0;
    int     cyc = 0;
    int     gap;
    bit     xf;

    @(posedge i_clk); #1;
    bus.i_start = 1'b1;
    bus.i_len   = LEN_W'(len);
    bus.i_valid = 1'b0;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;

    if (len == 0) begin
      @(negedge i_clk);
      check_val({tag, ".z_done"}, 64'(bus.o_done), 1);
      check_val({tag, ".z_acc"},  64'(bus.o_acc), 0);
      check_val({tag, ".z_ovf"},  64'(bus.o_ovf), 0);
      check_val({tag, ".z_rdy"},  64'(bus.o_ready), 0);
      @(negedge i_clk);
      check_val({tag, ".z_done_end"}, 64'(bus.o_done), 0);
      check_val({tag, ".z_rdy_end"},  64'(bus.o_ready), 0);
      check_val({tag, ".z_busy_end"}, 64'(bus.o_busy), 0);
      $display("seq %s len=0 acc=%0d ovf=%0d", tag, bus.o_acc, bus.o_ovf);
      return;
    end

    gap = $urandom_range(gap_max, 0);
    while (sent < len) begin
      if (cyc > 4 * len + 20) begin
        check_val({tag, ".timeout"}, 64'(sent), 64'(len));
        break;
      end
      if (gap > 0) begin
        bus.i_valid = 1'b0;
        bus.i_op1   = 4'($urandom);
        bus.i_op2   = 4'($urandom);
      end else begin
        bus.i_valid = 1'b1;
        bus.i_op1   = a_tab[sent];
        bus.i_op2   = b_tab[sent];
      end
      bus.i_start = stray ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge i_clk);
      xf = bus.o_ready && bus.i_valid;
      if (xf) begin
        exp_prod = longint'(bus.i_op1) * longint'(bus.i_op2);
        total += exp_prod;
        sent++;
        gap = $urandom_range(gap_max, 0);
      end else if (gap > 0) begin
        gap--;
      end
      @(posedge i_clk); #1;
      cyc++;
      if (chk_prod && xf) check_val({tag, ".prod"}, 64'(u_dut.prod_q), exp_prod);
    end

    exp_acc = (total > ACC_MAX) ? ACC_MAX : total;

    // Junk operands and stray starts while the block is not ready.
    bus.i_valid = stray;
    bus.i_op1   = 4'($urandom);
    bus.i_op2   = 4'($urandom);
    bus.i_start = stray;
    @(negedge i_clk);
    check_val({tag, ".rdy_drop"}, 64'(bus.o_ready), 0);
    check_val({tag, ".done_early"}, 64'(bus.o_done), 0);
    check_val({tag, ".busy"}, 64'(bus.o_busy), 1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_val({tag, ".done"}, 64'(bus.o_done), 1);
    check_val({tag, ".acc"},  64'(bus.o_acc), 64'(exp_acc));
    check_val({tag, ".ovf"},  64'(bus.o_ovf), 64'(total > ACC_MAX));
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    check_val({tag, ".done_end"}, 64'(bus.o_done), 0);
    check_val({tag, ".idle"},     64'(bus.o_busy), 0);
    check_val({tag, ".acc_hold"}, 64'(bus.o_acc), 64'(exp_acc));
    check_val({tag, ".ovf_hold"}, 64'(bus.o_ovf), 64'(total > ACC_MAX));
    $display("seq %s len=%0d total=%0d acc=%0d ovf=%0d", tag, len, total, bus.o_acc, bus.o_ovf);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    bus.i_valid = 1'b0;
    bus.i_op1   = '0;
    bus.i_op2   = '0;
    i_rst       = 1'b1;
    #12;
    check_val("rst.acc",   64'(bus.o_acc), 0);
    check_val("rst.ovf",   64'(bus.o_ovf), 0);
    check_val("rst.done",  64'(bus.o_done), 0);
    check_val("rst.busy",  64'(bus.o_busy), 0);
    check_val("rst.ready", 64'(bus.o_ready), 0);
    i_rst = 1'b0;

    // Basic sum
    a_tab[0] = 4'd15; b_tab[0] = 4'd15;
    a_tab[1] = 4'd2;  b_tab[1] = 4'd3;
    a_tab[2] = 4'd0;  b_tab[2] = 4'd9;
    run_seq("basic", 3, 0, 1'b0, 1'b1);

    // Handshake robustness with gaps, junk and stray starts
    a_tab[0] = 4'd1; b_tab[0] = 4'd1;
    a_tab[1] = 4'd3; b_tab[1] = 4'd4;
    a_tab[2] = 4'd7; b_tab[2] = 4'd7;
    a_tab[3] = 4'd5; b_tab[3] = 4'd2;
    run_seq("hshk", 4, 3, 1'b1, 1'b1);

    // Random sequences
    for (int s = 0; s < 6; s++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        a_tab[i] = 4'($urandom);
        b_tab[i] = 4'($urandom);
      end
      run_seq($sformatf("rand%0d", s), len, 3, 1'($urandom_range(1, 0)), 1'b1);
    end

    // Exhaustive product sweep
    for (int i = 0; i < 256; i++) begin
      a_tab[i] = 4'(i >> 4);
      b_tab[i] = 4'(i & 15);
    end
    run_seq("sweep", 256, 0, 1'b0, 1'b1);

    // Saturation: 292 terms of 225 exceed 65535
    for (int i = 0; i < 300; i++) begin
      a_tab[i] = 4'd15;
      b_tab[i] = 4'd15;
    end
    run_seq("sat", 300, 0, 1'b0, 1'b0);

    // Zero length after a saturated sequence must clear acc and ovf
    run_seq("zero", 0, 0, 1'b0, 1'b0);

    // Reset mid-sequence after 2 of 5 transfers
    @(posedge i_clk); #1;
    bus.i_start = 1'b1;
    bus.i_len   = LEN_W'(5);
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_op1   = 4'd9;
    bus.i_op2   = 4'd9;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check_val("mrst.acc",   64'(bus.o_acc), 0);
    check_val("mrst.ovf",   64'(bus.o_ovf), 0);
    check_val("mrst.done",  64'(bus.o_done), 0);
    check_val("mrst.busy",  64'(bus.o_busy), 0);
    check_val("mrst.ready", 64'(bus.o_ready), 0);
    @(negedge i_clk); #2;
    i_rst = 1'b0;
    a_tab[0] = 4'd6; b_tab[0] = 4'd7;
    run_seq("post_rst", 1, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
